zbuf_frame_scheduler: RTL and testbench
=======================================

# zbuf_frame_scheduler

Frame-level controller for the double-buffered colour/depth (z) buffers written by the rasterizer and read by the display path. It owns the front/back buffer select, clears the back buffer to far depth before each frame is drawn, and gates triangle hand-off into the rasterizer. It swaps buffers on a display frame boundary only when the back frame is complete; otherwise it drops the swap.

## Interface
Parameters:
- WIDTH, default 64: buffer width in pixels.
- HEIGHT, default 64: buffer height in pixels.
- CLEAR_COLOR, default 8'h00: colour field written during clear.
- CLEAR_DEPTH, default 9'h1FF: depth field written during clear (farthest).

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  reset; synchronous, active-high.
- new_frame  input  1  one-cycle pulse at the display frame boundary.
- obj_done  input  1  one-cycle pulse: upstream has issued all triangles for the frame.
- raster_busy_in  input  1  rasterizer is iterating a triangle.
- tri_valid_in  input  1  upstream has a triangle.
- tri_ready_out  output  1  triangle accepted when tri_valid_in && tri_ready_out.
- buf_sel  output  1  front-buffer select. 0 means buffer 0 is displayed and buffer 1 is written.
- clr_addr  output  17  clear write address.
- clr_data  output  17  {CLEAR_COLOR, CLEAR_DEPTH}, constant.
- clr_we0, clr_we1  output  1 each  clear write enables for buffer 0 and buffer 1.
- frame_ready  output  1  one-cycle pulse when the back frame completes.
- dropped_frames  output  8  saturating count of dropped swaps.
- tri_count  output  16  triangles accepted in the current frame.

## Operation
- N = WIDTH*HEIGHT. clr_addr is 17 bits and N ≤ 2^17.
- States: CLEAR, DRAW, DONE.
- **CLEAR**
  - Writes one word per cycle to the back buffer, at clr_addr 0..N-1 in order.
  - Back buffer is 1 when buf_sel=0 and 0 when buf_sel=1.
  - Exactly one of clr_we0/clr_we1 is high, selecting the back buffer. The other enable is always 0.
  - After the write to N-1, state goes to DRAW.
  - tri_ready_out=0.
- **DRAW**
  - tri_ready_out = !raster_busy_in.
  - Each accepted triangle increments tri_count (wraps at 2^16).
- **obj_done handling**
  - obj_done sets a pending flag in CLEAR or DRAW. It is ignored in DONE.
  - In DRAW, if pending && !raster_busy_in, state goes to DONE, frame_ready pulses, and pending clears.
- **DONE**
  - tri_ready_out=0.
  - On new_frame: buf_sel toggles, tri_count clears, and state goes to CLEAR with clr_addr=0.
- **Dropped swap**: new_frame in CLEAR or DRAW changes neither buf_sel nor state. dropped_frames increments and saturates at 255.
- **Simultaneous events**: new_frame and obj_done in the same DRAW cycle count as a drop. The DONE transition still occurs per the pending rule.
- **Reset**: clears everything and starts a clear of buffer 1.
  - Reset values: state CLEAR, buf_sel=0, clr_addr=0, clr_we0=0, clr_we1=0, tri_ready_out=0, frame_ready=0, dropped_frames=0, tri_count=0, pending=0.
  - Reset asserted mid-clear restarts the clear from address 0 on buffer 1.

## Timing
- All outputs are registered except tri_ready_out, which is combinational from state and raster_busy_in.
- **Clear burst**
  - First clr_we high: the cycle after reset deasserts, or the cycle after the new_frame edge.
  - The write enable stays high for exactly N consecutive cycles, with clr_addr stepping by 1 each cycle.
  - State is DRAW (tri_ready_out may assert) on the cycle after the last write.
- **Swap**: buf_sel changes on the edge that samples new_frame in DONE. The same edge begins the clear of the new back buffer.
- **frame_ready**: high for exactly the first cycle of DONE.
- **Clear vs rasterizer writes**: no overlap. Rasterizer writes only follow accepted triangles, and no triangle is accepted in CLEAR.
- **Minimum frame period**: N + 2 cycles, for a frame with zero triangles.

## Configuration
- ZSCHED_STATS_EN defined:
  - dropped_frames and tri_count operate as specified.
- ZSCHED_STATS_EN undefined:
  - Both counters and their logic are removed.
  - dropped_frames=8'd0 and tri_count=16'd0 permanently.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=HEIGHT=4, so N=16.
1. **Reset clear**: release rst_in.
   - clr_we1 high for 16 cycles, clr_addr 0..15, clr_data=17'h001FF.
   - clr_we0 never high.
   - DRAW on the next cycle.
2. **Full frame**: 3 triangles accepted, raster_busy_in high 5 cycles after each, then obj_done, then new_frame.
   - tri_count=3.
   - frame_ready pulses once.
   - buf_sel 0→1 on new_frame.
   - clr_we0 high 16 cycles.
   - tri_count=0 after the swap.
3. **Backpressure**: raster_busy_in=1 with tri_valid_in=1 in DRAW.
   - tri_ready_out=0 and no count increment.
   - obj_done during busy defers DONE until busy falls.
4. **Drops**: new_frame at cycle 5 of CLEAR and again in DRAW.
   - buf_sel unchanged, dropped_frames=2.
   - 300 dropped swaps leave dropped_frames at 255.
5. **Corner events**: obj_done issued during CLEAR, with no triangles.
   - DONE entered on the cycle after DRAW is entered.
   - Reset pulsed at clear address 9 restarts at address 0 on buffer 1, with buf_sel=0.
6. **ZSCHED_STATS_EN undefined**: rerun scenarios 2 and 4.
   - Counters read 0.
   - buf_sel and clr_we sequence identical to the stats build.

Source files
------------

// File: rtl/zbuf_frame_scheduler.sv
// Frame-level double-buffer controller: clears the back colour/depth buffer, gates triangle
// hand-off to the rasterizer and swaps buffers on frame boundaries. Define ZSCHED_STATS_EN for counters.
module zbuf_frame_scheduler #(
  parameter int          WIDTH       = 64,
  parameter int          HEIGHT      = 64,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00,
  parameter logic [8:0]  CLEAR_DEPTH = 9'h1FF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_frame,
  input  logic        obj_done,
  input  logic        raster_busy_in,
  input  logic        tri_valid_in,
  output logic        tri_ready_out,
  output logic        buf_sel,
  output logic [16:0] clr_addr,
  output logic [16:0] clr_data,
  output logic        clr_we0,
  output logic        clr_we1,
  output logic        frame_ready,
  output logic [7:0]  dropped_frames,
  output logic [15:0] tri_count
);

  localparam int          N         = WIDTH * HEIGHT;
  localparam logic [16:0] LAST_ADDR = 17'(N - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_DRAW,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   pending;
  logic   clearing;
  logic   last_write;
  logic   swap;
  logic   finish;

  assign clr_data   = {CLEAR_COLOR, CLEAR_DEPTH};
  assign clearing   = clr_we0 | clr_we1;
  assign last_write = clearing && (clr_addr == LAST_ADDR);
  assign swap       = (state == S_DONE) && new_frame;
  assign finish     = (state == S_DRAW) && pending && !raster_busy_in;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    tri_ready_out = 1'b0;
    case (state)
      S_CLEAR: if (last_write) state_nxt = S_DRAW;
      S_DRAW: begin
        tri_ready_out = !raster_busy_in;
        if (finish) state_nxt = S_DONE;
      end
      S_DONE:  if (new_frame) state_nxt = S_CLEAR;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_sel     <= 1'b0;
      clr_addr    <= '0;
      clr_we0     <= 1'b0;
      clr_we1     <= 1'b0;
      frame_ready <= 1'b0;
      pending     <= 1'b0;
    end else begin
      frame_ready <= finish;

      if (finish)                        pending <= 1'b0;
      else if (obj_done && state != S_DONE) pending <= 1'b1;

      if (swap) begin
        // The old front buffer becomes the new back buffer and is cleared first.
        buf_sel  <= ~buf_sel;
        clr_addr <= '0;
        clr_we0  <= ~buf_sel;
        clr_we1  <= buf_sel;
      end else if (state == S_CLEAR) begin
        if (!clearing) begin
          // Idle cycle after reset: launch the clear of the current back buffer.
          clr_addr <= '0;
          clr_we0  <= buf_sel;
          clr_we1  <= ~buf_sel;
        end else if (last_write) begin
          clr_addr <= '0;
          clr_we0  <= 1'b0;
          clr_we1  <= 1'b0;
        end else begin
          clr_addr <= clr_addr + 17'd1;
        end
      end
    end
  end

`ifdef ZSCHED_STATS_EN
  logic accept;
  assign accept = tri_valid_in && tri_ready_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dropped_frames <= '0;
      tri_count      <= '0;
    end else begin
      if (new_frame && state != S_DONE && dropped_frames != 8'hFF)
        dropped_frames <= dropped_frames + 8'd1;
      if (swap)        tri_count <= '0;
      else if (accept) tri_count <= tri_count + 16'd1;
    end
  end
`else
  logic unused_tri_valid;
  assign unused_tri_valid = tri_valid_in;
  assign dropped_frames   = 8'd0;
  assign tri_count        = 16'd0;
`endif

endmodule

// File: tb/tb_zbuf_frame_scheduler.sv
// Self-checking bench for zbuf_frame_scheduler (4x4 buffers): directed table, hand-written
// corner sequences and randomized traffic against a lock-step behavioural model.
module tb_zbuf_frame_scheduler;

  localparam int N = 16;
`ifdef ZSCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, new_frame, obj_done, raster_busy_in, tri_valid_in;
  logic        tri_ready_out, buf_sel, clr_we0, clr_we1, frame_ready;
  logic [16:0] clr_addr, clr_data;
  logic [7:0]  dropped_frames;
  logic [15:0] tri_count;

  zbuf_frame_scheduler #(.WIDTH(4), .HEIGHT(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .new_frame      (new_frame),
    .obj_done       (obj_done),
    .raster_busy_in (raster_busy_in),
    .tri_valid_in   (tri_valid_in),
    .tri_ready_out  (tri_ready_out),
    .buf_sel        (buf_sel),
    .clr_addr       (clr_addr),
    .clr_data       (clr_data),
    .clr_we0        (clr_we0),
    .clr_we1        (clr_we1),
    .frame_ready    (frame_ready),
    .dropped_frames (dropped_frames),
    .tri_count      (tri_count)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Behavioural model: frame phase, index of the word being cleared (-1 = not yet started),
  // which buffer is displayed, and the statistics as plain integers.
  typedef enum {PH_CLEAR, PH_DRAW, PH_DONE} phase_t;
  phase_t m_phase;
  bit     m_known = 0;
  int     m_wr, m_drop, m_tri;
  bit     m_front, m_pending, m_fr;

  task automatic model_step();
    bit acc;
    bit done_now;
    acc      = 0;
    done_now = 0;
    if (rst_in) begin
      m_known = 1; m_phase = PH_CLEAR; m_front = 0; m_wr = -1;
      m_pending = 0; m_fr = 0; m_drop = 0; m_tri = 0;
      return;
    end
    if (!m_known) return;
    acc = (m_phase == PH_DRAW) && !raster_busy_in && tri_valid_in;
    if (new_frame && m_phase != PH_DONE && m_drop < 255) m_drop++;
    if (acc) m_tri = (m_tri + 1) % 65536;
    case (m_phase)
      PH_CLEAR: begin
        if (obj_done) m_pending = 1;
        if (m_wr < 0) m_wr = 0;
        else if (m_wr == N - 1) begin m_phase = PH_DRAW; m_wr = -1; end
        else m_wr++;
      end
      PH_DRAW: begin
        if (m_pending && !raster_busy_in) begin
          m_phase = PH_DONE; m_pending = 0; done_now = 1;
        end else if (obj_done) m_pending = 1;
      end
      PH_DONE: begin
        if (new_frame) begin
          m_front = !m_front; m_tri = 0; m_phase = PH_CLEAR; m_wr = 0;
        end
      end
    endcase
    m_fr = done_now;
  endtask

  task automatic compare_model();
    bit exp_we;
    if (!m_known) return;
    exp_we = (m_phase == PH_CLEAR) && (m_wr >= 0);
    check("clr_we0", clr_we0, exp_we && m_front);
    check("clr_we1", clr_we1, exp_we && !m_front);
    if (m_phase == PH_CLEAR) check("clr_addr", clr_addr, exp_we ? m_wr : 0);
    check("tri_ready_out", tri_ready_out, (m_phase == PH_DRAW) && !raster_busy_in);
    check("frame_ready", frame_ready, m_fr);
    check("buf_sel", buf_sel, m_front);
    check("dropped_frames", dropped_frames, STATS ? m_drop : 0);
    check("tri_count", tri_count, STATS ? m_tri : 0);
    check("clr_data", clr_data, 17'h001FF);
  endtask

  // Apply inputs for one cycle and compare against the model before the edge.
  task automatic drive(input logic r, input logic nf, input logic od, input logic busy,
                       input logic tv);
    rst_in = r; new_frame = nf; obj_done = od; raster_busy_in = busy; tri_valid_in = tv;
    #1;
    compare_model();
  endtask

  task automatic clock();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic go_draw();
    for (int g = 0; g < 100; g++) begin
      drive(0, 0, 0, 0, 0);
      if (tri_ready_out) break;
      clock();
    end
    check("reach_draw", tri_ready_out, 1);
  endtask

  typedef struct {
    logic        r, nf, od, busy, tv;
    logic        we0, we1;
    logic [16:0] addr;
    bit          chk_addr;
    logic        rdy, fr, sel;
  } vec_t;

  function automatic vec_t mk(logic r, logic nf, logic od, logic busy, logic tv, logic we0,
                              logic we1, int addr, bit chk_addr, logic rdy, logic fr, logic sel);
    vec_t v;
    v.r = r; v.nf = nf; v.od = od; v.busy = busy; v.tv = tv;
    v.we0 = we0; v.we1 = we1; v.addr = 17'(addr); v.chk_addr = chk_addr;
    v.rdy = rdy; v.fr = fr; v.sel = sel;
    return v;
  endfunction

  vec_t tbl[32];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1;

    // Reset clear, obj_done during clear, minimum frame, swap, then reset at clear address 9.
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) tbl[1 + i] = mk(0, 0, i == 2, 0, 0, 0, 1, i, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tbl[19 + i] = mk(i == 9, 0, 0, 0, 0, 1, 0, i, 1, 0, 0, 1);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[30] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    tbl[31] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    clock();
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].r, tbl[i].nf, tbl[i].od, tbl[i].busy, tbl[i].tv);
      check($sformatf("tbl[%0d].clr_we0", i), clr_we0, tbl[i].we0);
      check($sformatf("tbl[%0d].clr_we1", i), clr_we1, tbl[i].we1);
      if (tbl[i].chk_addr) check($sformatf("tbl[%0d].clr_addr", i), clr_addr, tbl[i].addr);
      check($sformatf("tbl[%0d].tri_ready_out", i), tri_ready_out, tbl[i].rdy);
      check($sformatf("tbl[%0d].frame_ready", i), frame_ready, tbl[i].fr);
      check($sformatf("tbl[%0d].buf_sel", i), buf_sel, tbl[i].sel);
      clock();
    end

    // Full frame: three triangles each followed by five busy cycles, obj_done, swap.
    go_draw();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1);
      clock();
      for (int j = 0; j < 5; j++) begin drive(0, 0, 0, 1, 1); clock(); end
    end
    drive(0, 0, 0, 0, 0);
    check("frame_tri_count", tri_count, STATS ? 3 : 0);
    drive(0, 0, 1, 0, 0);
    clock();
    for (int g = 0; g < 10; g++) begin
      drive(0, 0, 0, 0, 0);
      if (frame_ready) break;
      clock();
    end
    check("frame_ready_pulse", frame_ready, 1);
    clock();
    drive(0, 0, 0, 0, 0);
    check("frame_ready_single", frame_ready, 0);
    check("done_tri_count", tri_count, STATS ? 3 : 0);
    clock();
    drive(0, 1, 0, 0, 0);
    check("pre_swap_buf_sel", buf_sel, 0);
    clock();
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0);
      if (i == 0) begin
        check("swap_buf_sel", buf_sel, 1);
        check("swap_tri_count", tri_count, 0);
      end
      cnt0 += int'(clr_we0);
      cnt1 += int'(clr_we1);
      clock();
    end
    check("swap_we0_cycles", cnt0, 16);
    check("swap_we1_cycles", cnt1, 0);

    // Backpressure: busy blocks hand-off and defers DONE.
    go_draw();
    drive(0, 0, 0, 1, 1);
    check("busy_ready", tri_ready_out, 0);
    clock();
    drive(0, 0, 0, 1, 0);
    check("busy_no_count", tri_count, 0);
    drive(0, 0, 1, 1, 0);
    clock();
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 1, 0);
      check("busy_defer_done", frame_ready, 0);
      clock();
    end
    drive(0, 0, 0, 0, 0);
    check("busy_fall_ready", tri_ready_out, 1);
    clock();
    drive(0, 0, 0, 0, 0);
    check("deferred_frame_ready", frame_ready, 1);
    clock();
    drive(0, 1, 0, 0, 0);
    clock();

    // Drops: new_frame at clear cycle 5 and in DRAW, then saturation.
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 0); clock(); end
    drive(0, 1, 0, 0, 0);
    check("drop_clear_addr", clr_addr, 5);
    clock();
    go_draw();
    drive(0, 1, 0, 0, 0);
    clock();
    drive(0, 0, 0, 0, 0);
    check("drop_count_2", dropped_frames, STATS ? 2 : 0);
    check("drop_buf_sel", buf_sel, 0);
    check("drop_still_draw", tri_ready_out, 1);
    for (int i = 0; i < 300; i++) begin drive(0, 1, 0, 0, 0); clock(); end
    drive(0, 0, 0, 0, 0);
    check("drop_saturate", dropped_frames, STATS ? 255 : 0);
    check("drop_sat_buf_sel", buf_sel, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      clock();
    end
    drive(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
